// File: rtl/switch_debouncer.sv
// Two-channel switch conditioner: per-channel synchroniser, stability-window FSM
// and counter, producing registered clean levels and one-cycle rise/fall pulses.
module switch_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_a,
  input  logic sw_b,
  output logic clean_a,
  output logic clean_b,
  output logic rise_a,
  output logic fall_a,
  output logic rise_b,
  output logic fall_b
);

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LO   = 2'd0,
    CHK_HI = 2'd1,
    S_HI   = 2'd2,
    CHK_LO = 2'd3
  } state_e;

  logic [NUM_CH-1:0] sw_v;
  logic [NUM_CH-1:0] clean_v;
  logic [NUM_CH-1:0] rise_v;
  logic [NUM_CH-1:0] fall_v;

  assign sw_v = {sw_b, sw_a};

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s;
    state_e                 state_q;
    state_e                 state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   clean_q;
    logic                   clean_d;
    logic                   rise_q;
    logic                   rise_d;
    logic                   fall_q;
    logic                   fall_d;

    // Shift the raw level into the synchroniser chain; the FSM only sees the last stage.
    always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], sw_v[ch]};
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Synchroniser flops.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= sync_d;
      end
    end

    // FSM state and stability counter register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= S_LO;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Next state: a candidate level must be seen N+1 times in a row; any opposite sample aborts.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        S_LO: begin
          if (s) begin
            state_d = CHK_HI;
            cnt_d   = '0;
          end
        end
        CHK_HI: begin
          if (!s) begin
            state_d = S_LO;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_HI;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_HI: begin
          if (!s) begin
            state_d = CHK_LO;
            cnt_d   = '0;
          end
        end
        CHK_LO: begin
          if (s) begin
            state_d = S_HI;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_LO;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = S_LO;
          cnt_d   = '0;
        end
      endcase
    end

    // Output decode: clean level changes and the matching pulse fires only on a confirmed check.
    always_comb begin
      clean_d = clean_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
        CHK_HI: begin
          if (s && (cnt_q == CNT_LAST)) begin
            clean_d = 1'b1;
            rise_d  = 1'b1;
          end
        end
        CHK_LO: begin
          if (!s && (cnt_q == CNT_LAST)) begin
            clean_d = 1'b0;
            fall_d  = 1'b1;
          end
        end
        default: begin
          clean_d = clean_q;
        end
      endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        clean_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        clean_q <= clean_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    assign clean_v[ch] = clean_q;
    assign rise_v[ch]  = rise_q;
    assign fall_v[ch]  = fall_q;
  end

  assign clean_a = clean_v[0];
  assign clean_b = clean_v[1];
  assign rise_a  = rise_v[0];
  assign rise_b  = rise_v[1];
  assign fall_a  = fall_v[0];
  assign fall_b  = fall_v[1];

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: directed scenarios plus random switching, checked
// every cycle against a run-length reference model.
module tb_switch_debouncer;

  localparam int unsigned N    = 4;
  localparam int unsigned SYNC = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic sw_a, sw_b;
  logic clean_a, clean_b, rise_a, fall_a, rise_b, fall_b;

  int checks = 0;
  int errors = 0;

  // Reference model: a delay line for the synchroniser, and per channel the length
  // of the current run of samples that disagree with the clean level.
  bit dqa[$];
  bit dqb[$];
  int run[2];
  bit mclean[2];
  bit mrise[2];
  bit mfall[2];

  int rcnt[2];
  int fcnt[2];
  bit bounce_b = 1'b0;

  switch_debouncer #(
    .DEBOUNCE_CYCLES(N),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw_a   (sw_a),
    .sw_b   (sw_b),
    .clean_a(clean_a),
    .clean_b(clean_b),
    .rise_a (rise_a),
    .fall_a (fall_a),
    .rise_b (rise_b),
    .fall_b (fall_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return 32'({clean_a, rise_a, fall_a, clean_b, rise_b, fall_b});
  endfunction

  function automatic logic [31:0] model_vec();
    return 32'({mclean[0], mrise[0], mfall[0], mclean[1], mrise[1], mfall[1]});
  endfunction

  task automatic model_reset();
    dqa.delete();
    dqb.delete();
    for (int i = 0; i < int'(SYNC); i++) begin
      dqa.push_back(1'b0);
      dqb.push_back(1'b0);
    end
    for (int c = 0; c < 2; c++) begin
      run[c] = 0; mclean[c] = 1'b0; mrise[c] = 1'b0; mfall[c] = 1'b0;
    end
  endtask

  task automatic model_judge(input int ch, input bit seen);
    mrise[ch] = 1'b0;
    mfall[ch] = 1'b0;
    if (seen != mclean[ch]) begin
      run[ch]++;
      if (run[ch] == int'(N) + 1) begin
        mclean[ch] = seen;
        mrise[ch]  = seen;
        mfall[ch]  = !seen;
        run[ch]    = 0;
      end
    end else begin
      run[ch] = 0;
    end
  endtask

  task automatic model_edge(input bit va, input bit vb);
    bit sa, sb;
    sa = dqa.pop_front();
    dqa.push_back(va);
    sb = dqb.pop_front();
    dqb.push_back(vb);
    model_judge(0, sa);
    model_judge(1, sb);
  endtask

  // One clock: advance model with the levels present at the edge, compare 1 ns later.
  task automatic step();
    bit va, vb;
    va = sw_a;
    vb = sw_b;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge(va, vb);
    #1;
    check("outs_vs_model", dut_vec(), model_vec());
    rcnt[0] += int'(rise_a);
    fcnt[0] += int'(fall_a);
    rcnt[1] += int'(rise_b);
    fcnt[1] += int'(fall_b);
    if (bounce_b) sw_b = 1'($urandom);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_counts();
    for (int c = 0; c < 2; c++) begin
      rcnt[c] = 0;
      fcnt[c] = 0;
    end
  endtask

  // Count edges until the clean level of channel ch equals lvl; -1 if it never does.
  task automatic wait_clean(input string tag, input int ch, input bit lvl, input int exp_edge);
    int n;
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 40) begin
      step();
      n++;
      hit = (((ch == 0) ? clean_a : clean_b) === lvl);
    end
    if (!hit) n = -1;
    check(tag, 32'(n), 32'(exp_edge));
  endtask

  initial begin
    rst_n = 1'b0;
    sw_a  = 1'b1;
    sw_b  = 1'b1;
    model_reset();
    clear_counts();

    // Reset with both switches high, then release.
    #1;
    check("reset_outs_async", dut_vec(), 32'd0);
    steps(3);
    check("reset_outs_held", dut_vec(), 32'd0);
    rst_n = 1'b1;
    wait_clean("reset_release_a_edge", 0, 1'b1, 7);
    check("reset_release_b_same_edge", 32'(clean_b), 32'd1);
    steps(3);
    check("reset_rise_a_count", 32'(rcnt[0]), 32'd1);
    check("reset_rise_b_count", 32'(rcnt[1]), 32'd1);

    // Return both channels low.
    sw_a = 1'b0;
    sw_b = 1'b0;
    steps(12);
    check("both_low", 32'({clean_a, clean_b}), 32'd0);

    // Bounce rejection on channel A.
    clear_counts();
    for (int k = 0; k < 5; k++) begin
      sw_a = 1'b1; steps(2);
      sw_a = 1'b0; steps(2);
    end
    check("bounce_clean_a_low", 32'(clean_a), 32'd0);
    check("bounce_no_rise_a", 32'(rcnt[0]), 32'd0);
    sw_a = 1'b1;
    wait_clean("bounce_then_hold_a_edge", 0, 1'b1, 7);

    // Width boundary on channel B: 4 cycles rejected, 5 accepted.
    clear_counts();
    sw_b = 1'b1; steps(4);
    sw_b = 1'b0; steps(10);
    check("width4_clean_b_low", 32'(clean_b), 32'd0);
    check("width4_no_rise_b", 32'(rcnt[1]), 32'd0);
    sw_b = 1'b1; steps(5);
    sw_b = 1'b0;
    // Rise lands at edge 7 of the pulse, i.e. edge 2 after the fall; fall at edge 7 after it.
    wait_clean("width5_rise_b_edge", 1, 1'b1, 2);
    wait_clean("width5_fall_b_edge", 1, 1'b0, 5);
    steps(3);
    check("width5_rise_b_count", 32'(rcnt[1]), 32'd1);
    check("width5_fall_b_count", 32'(fcnt[1]), 32'd1);

    // Falling edge on A with a one-cycle glitch high at cycle 3.
    clear_counts();
    sw_a = 1'b0; steps(2);
    sw_a = 1'b1; steps(1);
    sw_a = 1'b0;
    wait_clean("glitch_fall_a_edge", 0, 1'b0, 7);
    steps(3);
    check("glitch_fall_a_count", 32'(fcnt[0]), 32'd1);
    check("glitch_no_rise_a", 32'(rcnt[0]), 32'd0);

    // Independence: simultaneous change, then A timing under continuous B bounce.
    sw_a = 1'b1;
    sw_b = 1'b1;
    wait_clean("indep_a_edge", 0, 1'b1, 7);
    check("indep_b_same_edge", 32'(clean_b), 32'd1);
    bounce_b = 1'b1;
    sw_a = 1'b0;
    wait_clean("indep_a_fall_under_b_bounce", 0, 1'b0, 7);
    bounce_b = 1'b0;
    sw_b = 1'b1;
    steps(10);
    check("pre_async_b_high", 32'(clean_b), 32'd1);

    // Async reset two cycles into CHK_HI on channel A.
    clear_counts();
    sw_a = 1'b1;
    steps(5);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_outs_immediate", dut_vec(), 32'd0);
    steps(2);
    rst_n = 1'b1;
    wait_clean("async_rst_release_a_edge", 0, 1'b1, 7);
    check("async_rst_b_reacquired", 32'(clean_b), 32'd1);

    // Random switching with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      int unsigned span;
      span = ((i / 500) % 2 == 1) ? 15 : 3;
      if ($urandom_range(0, span) == 0) sw_a = ~sw_a;
      if ($urandom_range(0, span) == 0) sw_b = ~sw_b;
      if ($urandom_range(0, 799) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rand_async_rst", dut_vec(), 32'd0);
        steps(2);
        rst_n = 1'b1;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Two-channel input conditioning stage that sits directly upstream of the lab's two-input logic gates (the OR-gate stage's E/F inputs). It takes raw, asynchronous, bouncing slide-switch/push-button levels, synchronises them into the clock domain, and confirms each change only after the level has been stable for a programmable number of cycles. It outputs clean registered levels plus single-cycle rise/fall pulses per channel.

## Interface
- DEBOUNCE_CYCLES, 50000, stability window N in clock cycles; legal range 1..2^20. Internal counter width is $clog2(N+1).
- SYNC_STAGES, 2, flops in each input synchroniser; legal range 2..4.
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low; deassertion is synchronous to clk at the board level.
- sw_a  input  1  raw switch level, channel A (async, may bounce).
- sw_b  input  1  raw switch level, channel B (async, may bounce).
- clean_a  output  1  debounced level, channel A; drives gate input E.
- clean_b  output  1  debounced level, channel B; drives gate input F.
- rise_a, fall_a  output  1 each  one-cycle pulses on confirmed 0->1 and 1->0 of clean_a.
- rise_b, fall_b  output  1 each  same for channel B.

## Operation
- The two channels are fully independent, with identical logic. Each channel has its own synchroniser, FSM and counter, and there is no shared state.
- Synchroniser: a SYNC_STAGES-deep flop chain that resets to 0. Its last stage is `s`, and the FSM sees only `s`.
- FSM states, with reset state S_LO:
  - S_LO: clean=0. If s=1, go to CHK_HI with cnt<=0. Otherwise stay.
  - CHK_HI: clean=0. If s=0, go to S_LO with cnt<=0. If s=1 and cnt==N-1, go to S_HI: clean<=1, rise<=1. Otherwise cnt<=cnt+1.
  - S_HI: clean=1. If s=0, go to CHK_LO with cnt<=0. Otherwise stay.
  - CHK_LO: clean=1. If s=1, go to S_HI with cnt<=0. If s=0 and cnt==N-1, go to S_LO: clean<=0, fall<=1. Otherwise cnt<=cnt+1.
- cnt never exceeds N-1, so no wrap-around is possible. Any sample opposite to the candidate level aborts the check and restores the prior stable state, with no output change.
- rise/fall are registered. Each is high for exactly one cycle, on the cycle after the confirming edge, and is 0 in every other cycle. rise and fall of one channel are never high together.
- All outputs are registered, so there is no combinational path from sw_* to any output.

## Timing
- Reset: while rst_n=0, all of the following are 0 regardless of clk: clean_a/b, rise/fall_a/b, synchroniser flops, and cnt. Both FSMs are in S_LO.
- Reset mid-check (CHK_* state): the check is discarded immediately and restarts from S_LO after release.
- sw held high through reset release: treated as a normal 0->1 change. clean rises after the latency below, with a rise pulse.
- Latency: let sw change before edge 1 and hold. Then:
  - s changes at edge SYNC_STAGES.
  - The FSM enters CHK_* at edge SYNC_STAGES+1.
  - clean changes at edge SYNC_STAGES+N+1, and the pulse is high for the following cycle.
- Acceptance width: a level must be held for at least N+1 consecutive sampled cycles. With SYNC_STAGES=2, N=4, 5 cycles is accepted and 4 cycles is rejected.
- Simultaneous events: if sw_a and sw_b change on the same cycle, both clean outputs update on the same edge. A bounce on one channel has no effect on the other.
- N=1: clean follows s with one cycle of check. A single-cycle glitch is still rejected.

## Test plan
All scenarios use SYNC_STAGES=2, N=4 and a 10 ns clk.
- Reset behaviour: hold rst_n=0 for 3 cycles with sw_a=sw_b=1. All outputs must be 0. Release rst_n; clean_a and clean_b must go 1 at edge 7 after release, with rise_a and rise_b each high for exactly 1 cycle.
- Bounce rejection: from clean_a=0, drive sw_a 1,0,1,0 with widths of 2 cycles each, 5 times. clean_a must stay 0 with no rise_a. Then hold sw_a=1; clean_a must go 1 at edge 7 after the final rise.
- Width boundary: a sw_b high pulse of 4 cycles must produce no change on clean_b. A high pulse of 5 cycles must set clean_b=1 (rise_b x1). Returning low must give clean_b=0 at edge 7 (fall_b x1).
- Falling edge with glitch: from clean_a=1, drive sw_a low, pulse it high for 1 cycle at cycle 3, then hold low. clean_a must stay 1 until 7 edges after the final fall, then 0, with fall_a x1.
- Independence: toggle sw_a and sw_b on the same edge. clean_a and clean_b must change on the same edge. Bouncing sw_b throughout must leave clean_a timing unchanged.
- Async reset mid-check: pull rst_n low 2 cycles into CHK_HI on channel A. clean_a and rise_a must be 0 immediately, before the next clk edge. After release with sw_a still 1, clean_a must rise at edge 7.
